// File: rtl/insert_sort.sv
// insert_sort: stable single-cycle insertion sort of a 32-record frame, then an ascending unload
module insert_sort #(
  parameter int DEPTH = 32,
  parameter int TW = 23,
  parameter int CW = 2,
  parameter int IW = 5
) (
  input  logic clk,
  input  logic rst,
  output logic [CW-1:0] color_index,
  output logic [IW-1:0] image_out_index,
  output logic out_valid,
  output logic busy_rst,
  input  logic [CW-1:0] color,
  input  logic [TW-1:0] total,
  input  logic [IW-1:0] index,
  input  logic in_valid,
  output logic [CW+TW-1:0] data_in
);
  localparam int RW = IW + CW + TW;
  typedef enum logic {LOAD, UNLOAD} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] slot_q [DEPTH];
  logic [RW-1:0] slot_d [DEPTH];
  logic [RW-1:0] prev [DEPTH];
  logic [IW-1:0] count_q, count_d;
  logic [IW:0] ptr_q, ptr_d;
  logic [DEPTH-1:0] gt, gt_prev;
  logic [RW-1:0] rec, cur;
  logic out_valid_q, out_valid_d, busy_q, busy_d;
  logic [CW-1:0] color_index_q, color_index_d;
  logic [IW-1:0] image_q, image_d;
  logic [CW+TW-1:0] data_q, data_d;
  assign color_index = color_index_q;
  assign image_out_index = image_q;
  assign out_valid = out_valid_q;
  assign busy_rst = busy_q;
  assign data_in = data_q;
  always_comb begin
    rec = {index, color, total};
    cur = slot_q[ptr_q[IW-1:0]];
    prev[0] = '0;
    for (int i = 1; i < DEPTH; i++) prev[i] = slot_q[i-1];
    for (int i = 0; i < DEPTH; i++) gt[i] = (i < int'(count_q)) && (slot_q[i][TW-1:0] > total);
    gt_prev = {gt[DEPTH-2:0], 1'b0};
    state_d = state_q;
    slot_d = slot_q;
    count_d = count_q;
    ptr_d = ptr_q;
    busy_d = busy_q;
    out_valid_d = 1'b0;
    color_index_d = '0;
    image_d = '0;
    data_d = '0;
    if (state_q == LOAD) begin
      if (in_valid) begin
        for (int i = 0; i < DEPTH; i++)
          slot_d[i] = gt_prev[i] ? prev[i] : (gt[i] || i == int'(count_q)) ? rec : slot_q[i];
        count_d = count_q + 1'b1;
        if (count_q == IW'(DEPTH - 1)) begin
          state_d = UNLOAD;
          busy_d = 1'b1;
          ptr_d = '0;
        end
      end
    end else if (ptr_q[IW]) begin
      state_d = LOAD;
      busy_d = 1'b0;
      count_d = '0;
      ptr_d = '0;
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
    end else begin
      out_valid_d = 1'b1;
      image_d = cur[RW-1 -: IW];
      color_index_d = cur[TW+CW-1 -: CW];
      data_d = cur[TW+CW-1:0];
      ptr_d = ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      count_q <= '0;
      ptr_q <= '0;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      color_index_q <= '0;
      image_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      count_q <= count_d;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      color_index_q <= color_index_d;
      image_q <= image_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_insert_sort.sv
// tb_insert_sort: scoreboard bench for insert_sort with an independent stable selection-sort model
module tb_insert_sort;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [1:0] color, color_index;
  logic [22:0] total;
  logic [4:0] index, image_out_index;
  logic out_valid, busy_rst;
  logic [24:0] data_in;
  int total_n = 0, bad = 0;
  logic [29:0] exp_q [$];
  logic [4:0] mi [32];
  logic [1:0] mc [32];
  logic [22:0] mt [32];
  int mcount = 0, ph = 0, nout = 0;
  bit mbusy = 1'b0;
  insert_sort dut (
    .clk(clk), .rst(rst), .color_index(color_index), .image_out_index(image_out_index),
    .out_valid(out_valid), .busy_rst(busy_rst), .color(color), .total(total),
    .index(index), .in_valid(in_valid), .data_in(data_in)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_sorted();
    bit used [32];
    for (int j = 0; j < 32; j++) used[j] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      int b;
      b = -1;
      for (int j = 0; j < 32; j++)
        if (!used[j] && (b < 0 || mt[j] < mt[b])) b = j;
      used[b] = 1'b1;
      exp_q.push_back({mi[b], mc[b], mt[b]});
    end
  endtask
  task automatic tick(input bit v, input int ix, input int c, input int t);
    logic [29:0] e;
    in_valid = v;
    index = 5'(ix);
    color = 2'(c);
    total = 23'(t);
    if (!mbusy) begin
      if (v) begin
        mi[mcount] = index;
        mc[mcount] = color;
        mt[mcount] = total;
        mcount++;
        if (mcount == 32) begin
          push_sorted();
          mbusy = 1'b1;
          ph = 0;
          nout = 0;
        end
      end
    end else begin
      ph++;
      if (ph == 33) begin
        chk("frame_count", nout, 32);
        mbusy = 1'b0;
        mcount = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy", {31'b0, busy_rst}, {31'b0, mbusy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, (mbusy && ph >= 1)});
    if (mbusy && ph >= 1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nout++;
      chk("index", {27'b0, image_out_index}, {27'b0, e[29:25]});
      chk("color", {30'b0, color_index}, {30'b0, e[24:23]});
      chk("data", {7'b0, data_in}, {7'b0, e[24:0]});
    end else begin
      chk("idle_data", {color_index, image_out_index, data_in}, 32'd0);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    mbusy = 1'b0;
    mcount = 0;
    exp_q.delete();
    tick(0, 0, 0, 0);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    index = '0;
    color = '0;
    total = '0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      int ix, c, t;
      ix = k;
      c = k % 4;
      t = (k * 1237 + 311) % 4700 + 2;
      if (k == 0) t = 2514;
      if (k == 1) t = 1600;
      if (k == 2) t = 4512;
      if (k == 5) begin ix = 18; t = 2891; end
      if (k == 18) t = 1679;
      if (k == 30) begin t = 1; c = 0; end
      if (k == 31) begin t = 1111; c = 1; end
      tick(1, ix, c, t);
      repeat (3) tick(0, 0, 0, 0);
    end
    repeat (10) tick(0, 0, 0, 0);
    tick(1, 7, 0, 0);
    repeat (30) tick(0, 0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      tick(1, k, k % 4, 500);
      tick(0, 0, 0, 0);
    end
    repeat (35) tick(0, 0, 0, 0);
    for (int k = 0; k < 32; k++) tick(1, k, 3 - k % 4, 31 - k);
    repeat (35) tick(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) tick(1, k, 1, 100 + k);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      int t;
      t = int'($urandom_range(0, 23'h7fffff));
      if (k == 3) t = 0;
      if (k == 4) t = 23'h7fffff;
      if (k == 9) t = 23'h7fffff;
      tick(1, 31 - k, k % 4, t);
    end
    repeat (35) tick(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total_n, bad);
    $finish;
  end
endmodule
